// File: rtl/iter_div_unit.sv
// Iterative radix-2 restoring divider for the EX stage.
// One unit covers signed and unsigned div/mod: operands are reduced to
// magnitudes at accept, divided unsigned one quotient bit per cycle, and the
// signs are restored on the last iteration. A zero divisor skips the loop.
//
// Handshake (both sides): a transfer happens on a rising clk edge where
// valid and ready are both high. in_ready is high only in IDLE; out_valid is
// high only in DONE and stays high, with stable data, until out_ready.
// flush and reset drop any in-flight operation; neither side transfers in a
// cycle where flush is high.
module iter_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_signed,
    input  logic [WIDTH-1:0] in_dividend,
    input  logic [WIDTH-1:0] in_divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quotient,
    output logic [WIDTH-1:0] out_remainder,
    output logic             out_div_zero,
    output logic             busy,
    output logic [1:0]       dbg_state      // 0 IDLE, 1 CALC, 2 DONE
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Working registers of the iteration.
    logic [WIDTH-1:0] r_dvd;       // dividend magnitude; quotient bits shift in at the bottom
    logic [WIDTH-1:0] r_dvs;       // divisor magnitude
    logic [WIDTH-1:0] r_rem;       // partial remainder
    logic [CNT_W-1:0] r_cnt;       // iterations still to run
    logic             r_sign_q;
    logic             r_sign_r;

    // Registered results presented on the output side.
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rmd;
    logic             r_dz;

    logic             w_accept;
    logic             w_dvs_zero;
    logic             w_dvd_neg;
    logic             w_dvs_neg;
    logic [WIDTH-1:0] w_dvd_abs;
    logic [WIDTH-1:0] w_dvs_abs;
    logic [WIDTH:0]   w_rem_sh;
    logic             w_ge;
    logic [WIDTH-1:0] w_sub;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_dvd_next;
    logic             w_last;

    // Operand preparation: magnitudes are taken only for signed requests.
    // |-2^(W-1)| = 2^(W-1) is representable as an unsigned W-bit value.
    assign w_accept   = in_valid & in_ready & ~flush;
    assign w_dvs_zero = (in_divisor == '0);
    assign w_dvd_neg  = in_signed & in_dividend[WIDTH-1];
    assign w_dvs_neg  = in_signed & in_divisor[WIDTH-1];
    assign w_dvd_abs  = w_dvd_neg ? (~in_dividend + 1'b1) : in_dividend;
    assign w_dvs_abs  = w_dvs_neg ? (~in_divisor + 1'b1) : in_divisor;

    // One restoring step. The shifted remainder is WIDTH+1 bits so the
    // comparison never loses the carry out of the top bit. When the compare
    // succeeds the true difference is below the divisor, so a WIDTH-bit
    // subtract yields it exactly.
    assign w_rem_sh   = {r_rem, r_dvd[WIDTH-1]};
    assign w_ge       = (w_rem_sh >= {1'b0, r_dvs});
    assign w_sub      = w_rem_sh[WIDTH-1:0] - r_dvs;
    assign w_rem_next = w_ge ? w_sub : w_rem_sh[WIDTH-1:0];
    assign w_dvd_next = {r_dvd[WIDTH-2:0], w_ge};
    assign w_last     = (r_cnt == CNT_W'(1));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and status outputs; flush wins over accept and out_ready.
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b1;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (w_accept) begin
                    w_state_next = w_dvs_zero ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (flush) begin
                    w_state_next = S_IDLE;
                end else if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (flush || out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Datapath: load at accept, iterate in CALC, register signed results on the last step.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dvd    <= '0;
            r_dvs    <= '0;
            r_rem    <= '0;
            r_cnt    <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_quo    <= '0;
            r_rmd    <= '0;
            r_dz     <= 1'b0;
        end else if (flush) begin
            r_dz <= 1'b0;
        end else if (w_accept) begin
            if (w_dvs_zero) begin
                r_quo <= '1;
                r_rmd <= in_dividend;
                r_dz  <= 1'b1;
            end else begin
                r_dvd    <= w_dvd_abs;
                r_dvs    <= w_dvs_abs;
                r_rem    <= '0;
                r_cnt    <= CNT_W'(WIDTH);
                r_sign_q <= w_dvd_neg ^ w_dvs_neg;
                r_sign_r <= w_dvd_neg;
                r_dz     <= 1'b0;
            end
        end else if (r_state == S_CALC) begin
            r_rem <= w_rem_next;
            r_dvd <= w_dvd_next;
            r_cnt <= r_cnt - CNT_W'(1);
            if (w_last) begin
                r_quo <= r_sign_q ? (~w_dvd_next + 1'b1) : w_dvd_next;
                r_rmd <= r_sign_r ? (~w_rem_next + 1'b1) : w_rem_next;
            end
        end
    end

    assign out_quotient  = r_quo;
    assign out_remainder = r_rmd;
    assign out_div_zero  = r_dz;
    assign dbg_state     = r_state;

endmodule
